muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or restoring
// divide, one sign-fix cycle, then a one-cycle done strobe with a held result.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            kill,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            is_m,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [2:0]          f3_r;
    logic                sa_r;
    logic                sb_r;
    logic [XLEN-1:0]     b_r;
    logic [2*XLEN:0]     acc_r;
    logic [CW-1:0]       cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic [2:0]          f3_s;
    logic                sa_s;
    logic                sb_s;
    logic                accept_s;
    logic [XLEN:0]       upper_s;
    logic [2*XLEN:0]     mul_next_s;
    logic [2*XLEN:0]     sh_s;
    logic [XLEN+1:0]     diff_s;
    logic [2*XLEN:0]     div_next_s;
    logic [2*XLEN:0]     step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     fix_s;
    logic                unused_s;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
        cneg = neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        cneg_wide = neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    assign is_m     = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    assign f3_s     = inst[14:12];
    // A done strobe still showing means the FSM only just left DONE; hold off one more cycle
    assign accept_s = start & is_m & ~kill & ~done_r;
    assign unused_s = ^{inst[24:15], inst[11:7], diff_s[XLEN]};

    // Operand sign flags for the instruction being offered
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (f3_s)
            3'd1, 3'd4, 3'd6: begin
                sa_s = in_a[XLEN-1];
                sb_s = in_b[XLEN-1];
            end
            3'd2: begin
                sa_s = in_a[XLEN-1];
                sb_s = 1'b0;
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
    end

    // One iteration of the multiply or divide loop
    always_comb begin
        if (acc_r[0]) begin
            upper_s = acc_r[2*XLEN:XLEN] + {1'b0, b_r};
        end else begin
            upper_s = acc_r[2*XLEN:XLEN];
        end
        mul_next_s = {1'b0, upper_s, acc_r[XLEN-1:1]};
        sh_s       = {acc_r[2*XLEN-1:0], 1'b0};
        diff_s     = {1'b0, sh_s[2*XLEN:XLEN]} - {2'b00, b_r};
        if (diff_s[XLEN+1]) begin
            div_next_s = sh_s;
        end else begin
            div_next_s = {1'b0, diff_s[XLEN-1:0], sh_s[XLEN-1:1], 1'b1};
        end
        if (f3_r[2]) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end

    // Sign correction and half selection; divisor==0 leaves the all-ones quotient alone
    always_comb begin
        prod_s = cneg_wide(acc_r[2*XLEN-1:0], sa_r ^ sb_r);
        if (f3_r[2]) begin
            if (f3_r[1]) begin
                fix_s = cneg(acc_r[2*XLEN-1:XLEN], sa_r);
            end else begin
                fix_s = cneg(acc_r[XLEN-1:0], (sa_r ^ sb_r) & (b_r != {XLEN{1'b0}}));
            end
        end else if (f3_r[1:0] == 2'b00) begin
            fix_s = prod_s[XLEN-1:0];
        end else begin
            fix_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM, datapath registers and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            f3_r     <= 3'd0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            b_r      <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN+1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        f3_r    <= f3_s;
                        sa_r    <= sa_s;
                        sb_r    <= sb_s;
                        b_r     <= cneg(in_b, sb_s);
                        acc_r   <= {{(XLEN+1){1'b0}}, cneg(in_a, sa_s)};
                        cnt_r   <= CW'(XLEN-1);
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (kill) begin
                        state_r <= IDLE;
                    end else begin
                        busy_r <= 1'b1;
                        acc_r  <= step_s;
                        if (cnt_r == {CW{1'b0}}) begin
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                end
                FIX: begin
                    if (kill) begin
                        state_r <= IDLE;
                    end else begin
                        busy_r   <= 1'b1;
                        result_r <= fix_s;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results queued at issue, checked on done.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        kill;
    logic [31:0] inst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        is_m;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          done_cnt  = 0;
    int          n_issued  = 0;
    logic [31:0] last_exp  = 32'h0;
    logic [31:0] exp_q[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .kill   (kill),
        .inst   (inst),
        .in_a   (in_a),
        .in_b   (in_b),
        .is_m   (is_m),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_inst(input logic [2:0] f3);
        m_inst = {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction

    // Reference arithmetic built on native 64-bit and signed operators
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        x;
        logic [63:0]        y;
        logic [63:0]        p;
        logic signed [31:0] as;
        logic signed [31:0] bs;
        logic               ovf;
        as  = a;
        bs  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        x   = (f3 == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        y   = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = x * y;
        case (f3)
            3'd0:    model = p[31:0];
            3'd1,
            3'd2,
            3'd3:    model = p[63:32];
            3'd4:    model = (b == 32'h0) ? 32'hFFFFFFFF : (ovf ? a : 32'(as / bs));
            3'd5:    model = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6:    model = (b == 32'h0) ? a : (ovf ? 32'h0 : 32'(as % bs));
            default: model = (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every done strobe retires the oldest queued expectation
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done_cnt), 32'(n_issued));
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    // Issue one operation and time it; poke also offers stray starts while busy and at done
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit poke);
        int cyc;
        int bcnt;
        inst  = m_inst(f3);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        exp_q.push_back(exp);
        n_issued++;
        last_exp = exp;
        @(posedge clk); #1;
        start = 1'b0;
        in_a  = ~a;
        in_b  = ~b;
        check("busy_at_accept", 32'(busy), 32'h0);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 60) begin
            start = poke && (cyc == 5 || cyc == 33);
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) bcnt++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'd34);
        check("busy_cycles", 32'(bcnt), 32'd33);
        check("busy_at_done", 32'(busy), 32'h0);
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (40) @(posedge clk);
            #1;
            check("poke_no_extra_done", 32'(done_cnt), 32'(n_issued));
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        resetn = 1'b0;
        start  = 1'b0;
        kill   = 1'b0;
        inst   = 32'h0;
        in_a   = 32'h0;
        in_b   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", result, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        inst = m_inst(3'd0);
        #1 check("is_m_mul", 32'(is_m), 32'h1);
        inst = {7'b0000000, 10'd0, 3'd0, 5'd0, 7'b0110011};
        #1 check("is_m_add", 32'(is_m), 32'h0);
        inst = {7'b0000001, 10'd0, 3'd0, 5'd0, 7'b0010011};
        #1 check("is_m_opimm", 32'(is_m), 32'h0);

        issue(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
        issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        issue(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
        issue(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        issue(3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
        issue(3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
        issue(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0);
        issue(3'd5, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0);
        issue(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0);
        issue(3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(rf3, ra, rb, model(rf3, ra, rb), 1'b0);
        end

        // kill in RUN: no done, result held, immediate restart accepted
        inst  = m_inst(3'd4);
        in_a  = 32'd1000;
        in_b  = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'h0);
        check("kill_result", result, last_exp);
        issue(3'd5, 32'd1000, 32'd3, 32'd333, 1'b0);

        // kill in IDLE and non-M instructions block acceptance
        inst  = m_inst(3'd0);
        in_a  = 32'd5;
        in_b  = 32'd5;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        inst = {7'b0000000, 10'd0, 3'd0, 5'd0, 7'b0110011};
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("blocked_busy", 32'(busy), 32'h0);
        repeat (40) @(posedge clk);
        #1;
        check("blocked_no_done", 32'(done_cnt), 32'(n_issued));

        // reset mid-RUN clears outputs without waiting for a clock edge
        inst  = m_inst(3'd0);
        in_a  = 32'd9;
        in_b  = 32'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_result", result, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_done", 32'(done_cnt), 32'(n_issued));
        issue(3'd0, 32'd9, 32'd9, 32'd81, 1'b0);

        repeat (5) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
